// File: rtl/softmax_row_loader_if.sv
// -----------------------------------------------------------------------------
// softmax_row_loader_if
//  Groups the signals between the row loader and its neighbours:
//   - narrow word stream in   : i_s_valid / o_s_ready / i_s_data / i_s_last / i_mode
//   - BRAM port-A write side  : o_cena / o_wea / o_addra / o_dina
//   - sequencer hand-off      : o_start / i_busy
//   - framing error pulse     : o_err
//  Signal names keep the loader's point of view (i_ = into the loader).
//  Modports:
//   master : the environment (stream source, BRAM, sequencer) driving the loader
//   slave  : the loader itself
// -----------------------------------------------------------------------------
interface softmax_row_loader_if #(
  parameter int WORD_W = 64,
  parameter int ROW_W  = 1024,
  parameter int MODE_W = 4,
  parameter int ADDR_W = 5
);
  logic                    i_s_valid;
  logic                    o_s_ready;
  logic [WORD_W-1:0]       i_s_data;
  logic                    i_s_last;
  logic [MODE_W-1:0]       i_mode;
  logic                    o_cena;
  logic                    o_wea;
  logic [ADDR_W-1:0]       o_addra;
  logic [ROW_W+MODE_W-1:0] o_dina;
  logic                    o_start;
  logic                    i_busy;
  logic                    o_err;

  modport master (
    output i_s_valid, i_s_data, i_s_last, i_mode, i_busy,
    input  o_s_ready, o_cena, o_wea, o_addra, o_dina, o_start, o_err
  );

  modport slave (
    input  i_s_valid, i_s_data, i_s_last, i_mode, i_busy,
    output o_s_ready, o_cena, o_wea, o_addra, o_dina, o_start, o_err
  );
endinterface

// File: rtl/softmax_row_loader.sv
// -----------------------------------------------------------------------------
// softmax_row_loader
//  Packs a WORD_W valid/ready stream into {mode, ROW_W} rows and writes N_ROWS
//  of them to consecutive BRAM addresses starting at BASE_ADDR. After the last
//  row it pulses o_start to the softmax sequencer, then waits for the sequencer
//  to report busy before re-arming. A new frame is only accepted while the
//  sequencer is idle.
//  Ports:
//   i_clk  clock
//   i_rst  asynchronous reset, active-high
//   i_en   clock enable; low freezes all state and deasserts every pulse
//   bus    softmax_row_loader_if.slave (stream in, BRAM write, start/busy, err)
//  All bus outputs are registered except o_s_ready.
// -----------------------------------------------------------------------------
module softmax_row_loader #(
  parameter int WORD_W    = 64,
  parameter int ROW_W     = 1024,
  parameter int MODE_W    = 4,
  parameter int N_ROWS    = 12,
  parameter int ADDR_W    = 5,
  parameter int BASE_ADDR = 0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_en,
  softmax_row_loader_if.slave  bus
);

  localparam int WPR  = ROW_W / WORD_W;
  localparam int WC_W = (WPR > 1) ? $clog2(WPR) : 1;
  localparam int RC_W = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;

  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(WPR - 1);
  localparam logic [RC_W-1:0] LAST_ROW  = RC_W'(N_ROWS - 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FILL  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_KICK  = 3'd3;
  localparam logic [2:0] ST_WAIT  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  logic [2:0]              state;
  logic [WC_W-1:0]         word_cnt;
  logic [RC_W-1:0]         row_cnt;
  logic [ROW_W-1:0]        row_buf;
  logic [MODE_W-1:0]       mode_q;

  logic                    cena_q;
  logic                    wea_q;
  logic [ADDR_W-1:0]       addra_q;
  logic [ROW_W+MODE_W-1:0] dina_q;
  logic                    start_q;
  logic                    err_q;

  logic                    s_ready;
  logic                    hs;
  logic                    final_word;
  logic                    frame_err;
  logic [ROW_W-1:0]        row_next;
  logic [MODE_W-1:0]       mode_next;

  assign s_ready    = i_en && (state == ST_FILL);
  assign hs         = bus.i_s_valid && s_ready;
  assign final_word = (row_cnt == LAST_ROW) && (word_cnt == LAST_WORD);
  // i_s_last must be high on exactly the final word of the frame.
  assign frame_err  = bus.i_s_last != final_word;

  // Row image including the word being accepted this cycle, so the write on
  // the last word of a row needs no extra cycle to settle the buffer.
  always_comb begin
    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first; that keeps them latch-free.
    row_next = row_buf;
    row_next[word_cnt*WORD_W +: WORD_W] = bus.i_s_data;
    mode_next = (word_cnt == '0) ? bus.i_mode : mode_q;
  end

  // NOTE: the packing buffer is pure datapath and has no reset; every word is
  // overwritten before the row is written, so stale contents never escape.
  always_ff @(posedge i_clk) begin
    if (hs) begin
      row_buf <= row_next;
      mode_q  <= mode_next;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state    <= ST_IDLE;
      word_cnt <= '0;
      row_cnt  <= '0;
      cena_q   <= 1'b0;
      wea_q    <= 1'b0;
      addra_q  <= ADDR_W'(BASE_ADDR);
      dina_q   <= '0;
      start_q  <= 1'b0;
      err_q    <= 1'b0;
    end else if (!i_en) begin
      // Frozen: state holds, pulses drop and are re-issued once enabled.
      cena_q  <= 1'b0;
      wea_q   <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments; the pulse
      // defaults below are overridden later in the same block where needed.
      cena_q  <= 1'b0;
      wea_q   <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (!bus.i_busy) state <= ST_FILL;
        end
        ST_FILL: begin
          if (hs) begin
            if (frame_err) begin
              // Abort the frame; the current partial row is never written.
              state    <= ST_ERR;
              err_q    <= 1'b1;
              word_cnt <= '0;
              row_cnt  <= '0;
            end else if (word_cnt == LAST_WORD) begin
              state    <= ST_WRITE;
              word_cnt <= '0;
              cena_q   <= 1'b1;
              wea_q    <= 1'b1;
              addra_q  <= ADDR_W'(BASE_ADDR) + ADDR_W'(row_cnt);
              dina_q   <= {mode_next, row_next};
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        ST_WRITE: begin
          // The strobe counts only once it was visible in an enabled cycle;
          // otherwise it is presented again with the same address and data.
          if (wea_q) begin
            if (row_cnt == LAST_ROW) begin
              row_cnt <= '0;
              state   <= ST_KICK;
              start_q <= 1'b1;
            end else begin
              row_cnt <= row_cnt + 1'b1;
              state   <= ST_FILL;
            end
          end else begin
            cena_q <= 1'b1;
            wea_q  <= 1'b1;
          end
        end
        ST_KICK: begin
          if (start_q) state <= ST_WAIT;
          else         start_q <= 1'b1;
        end
        ST_ERR: begin
          if (err_q) state <= ST_IDLE;
          else       err_q <= 1'b1;
        end
        ST_WAIT: begin
          // The sequencer must acknowledge with busy before the next frame.
          if (bus.i_busy) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_s_ready = s_ready;
  assign bus.o_cena    = cena_q;
  assign bus.o_wea     = wea_q;
  assign bus.o_addra   = addra_q;
  assign bus.o_dina    = dina_q;
  assign bus.o_start   = start_q;
  assign bus.o_err     = err_q;

endmodule

// File: tb/tb_softmax_row_loader.sv
// -----------------------------------------------------------------------------
// tb_softmax_row_loader
//  Drives frames into softmax_row_loader and compares the BRAM writes, start
//  and error pulses with a frame-level reference: every complete row before
//  the first framing error is written at BASE_ADDR+row as {mode of word 0,
//  words concatenated LSB-first}; o_start follows a clean frame only.
// -----------------------------------------------------------------------------
module tb_softmax_row_loader;

  localparam int WORD_W = 64;
  localparam int ROW_W  = 1024;
  localparam int MODE_W = 4;
  localparam int N_ROWS = 12;
  localparam int ADDR_W = 5;
  localparam int WPR    = ROW_W / WORD_W;
  localparam int FRAME  = WPR * N_ROWS;
  localparam int DW     = ROW_W + MODE_W;

  logic i_clk = 1'b0;
  logic i_rst;
  logic i_en;

  softmax_row_loader_if #(
    .WORD_W(WORD_W), .ROW_W(ROW_W), .MODE_W(MODE_W), .ADDR_W(ADDR_W)
  ) bus ();

  softmax_row_loader #(
    .WORD_W(WORD_W), .ROW_W(ROW_W), .MODE_W(MODE_W),
    .N_ROWS(N_ROWS), .ADDR_W(ADDR_W), .BASE_ADDR(0)
  ) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (i_en),
    .bus   (bus.slave)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Observed activity log, sampled mid-cycle.
  logic [ADDR_W-1:0] wr_addr_q [$];
  logic [DW-1:0]     wr_data_q [$];
  int                wr_cyc_q  [$];
  int                start_q   [$];
  int                err_q     [$];

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (bus.o_cena && bus.o_wea) begin
        wr_addr_q.push_back(bus.o_addra);
        wr_data_q.push_back(bus.o_dina);
        wr_cyc_q.push_back(cyc);
      end
      if (bus.o_start) start_q.push_back(cyc);
      if (bus.o_err)   err_q.push_back(cyc);
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
  endtask

  // Current frame stimulus and the cycle each word was accepted.
  logic [WORD_W-1:0] fw [FRAME];
  logic [MODE_W-1:0] fm [FRAME];
  int                hs_cyc [FRAME];
  bit                aborted;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic send_word(input int i, input bit last, input bit gaps);
    int budget;
    budget = 300;
    bus.i_s_valid = 1'b0;
    if (gaps) repeat ($urandom_range(0, 2)) tick();
    bus.i_s_data  = fw[i];
    bus.i_mode    = fm[i];
    bus.i_s_last  = last;
    bus.i_s_valid = 1'b1;
    forever begin
      if (gaps) i_en = ($urandom_range(0, 3) != 0);
      @(negedge i_clk);
      if (bus.o_s_ready) begin
        hs_cyc[i] = cyc;
        tick();
        break;
      end
      tick();
      budget--;
      if (budget == 0) begin
        check($sformatf("handshake_timeout_w%0d", i), bus.o_s_ready, 1'b1);
        aborted = 1'b1;
        break;
      end
    end
    bus.i_s_valid = 1'b0;
    bus.i_s_last  = 1'b0;
    i_en          = 1'b1;
  endtask

  task automatic run_frame(input int n, input int last_at, input bit pattern, input bit gaps);
    aborted = 1'b0;
    for (int i = 0; i < n; i++) begin
      int r;
      int w;
      r = i / WPR;
      w = i % WPR;
      fw[i] = pattern ? {32'(r), 32'(w)} : {$urandom, $urandom};
      fm[i] = pattern ? 4'h5 : MODE_W'($urandom);
    end
    for (int i = 0; i < n; i++)
      if (!aborted) send_word(i, i == last_at, gaps);
  endtask

  // Let the tail of the frame drain; acknowledge o_start like the sequencer.
  task automatic settle(input bit ack);
    repeat (4) tick();
    if (ack) begin
      bus.i_busy = 1'b1;
      repeat (3) tick();
      bus.i_busy = 1'b0;
    end
    repeat (2) tick();
  endtask

  function automatic logic [DW-1:0] exp_row(input int r);
    logic [ROW_W-1:0] d;
    d = '0;
    for (int w = 0; w < WPR; w++) d[w*WORD_W +: WORD_W] = fw[r*WPR + w];
    return {fm[r*WPR], d};
  endfunction

  task automatic check_frame(input string name, input int wm, input int sm, input int em,
                             input int exp_rows, input bit exp_start, input int err_word,
                             input bit exact);
    for (int r = 0; r < N_ROWS; r++) begin
      bit            found;
      logic [DW-1:0] data;
      int            first_cyc;
      found = 1'b0;
      data = '0;
      first_cyc = 0;
      for (int k = wm; k < wr_addr_q.size(); k++) begin
        if (int'(wr_addr_q[k]) == r) begin
          if (!found) first_cyc = wr_cyc_q[k];
          found = 1'b1;
          data = wr_data_q[k];
        end
      end
      check($sformatf("%s_row%0d_written", name, r), found, r < exp_rows);
      if (found && r < exp_rows) begin
        check($sformatf("%s_row%0d_data", name, r), data, exp_row(r));
        if (exact)
          check($sformatf("%s_row%0d_latency", name, r), first_cyc, hs_cyc[r*WPR + WPR - 1] + 1);
      end
    end
    if (exact) check($sformatf("%s_write_count", name), wr_addr_q.size() - wm, exp_rows);
    check($sformatf("%s_start_count", name), start_q.size() - sm, exp_start);
    if (exp_start && start_q.size() > sm && exact)
      check($sformatf("%s_start_latency", name), start_q[sm], hs_cyc[FRAME-1] + 2);
    check($sformatf("%s_err_count", name), err_q.size() - em, err_word >= 0);
    if (err_word >= 0 && err_q.size() > em)
      check($sformatf("%s_err_latency", name), err_q[em], hs_cyc[err_word] + 1);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_ready"}, bus.o_s_ready, 1'b0);
    check({name, "_cena"},  bus.o_cena,    1'b0);
    check({name, "_wea"},   bus.o_wea,     1'b0);
    check({name, "_addra"}, bus.o_addra,   '0);
    check({name, "_dina"},  bus.o_dina,    '0);
    check({name, "_start"}, bus.o_start,   1'b0);
    check({name, "_err"},   bus.o_err,     1'b0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int wm, sm, em;
    i_rst = 1'b1;
    i_en  = 1'b1;
    bus.i_s_valid = 1'b0;
    bus.i_s_data  = '0;
    bus.i_s_last  = 1'b0;
    bus.i_mode    = '0;
    bus.i_busy    = 1'b1;
    repeat (2) tick();
    check_idle_outputs("reset");
    i_rst = 1'b0;

    // Busy sequencer keeps the loader in IDLE; release opens FILL a cycle later.
    repeat (3) begin
      @(negedge i_clk);
      check("busy_hold_ready", bus.o_s_ready, 1'b0);
    end
    tick();
    bus.i_busy = 1'b0;
    @(negedge i_clk);
    check("ready_same_cycle_as_busy_drop", bus.o_s_ready, 1'b0);
    @(negedge i_clk);
    check("ready_after_busy_drop", bus.o_s_ready, 1'b1);
    tick();

    // Clean pattern frame, back-to-back words.
    wm = wr_addr_q.size(); sm = start_q.size(); em = err_q.size();
    run_frame(FRAME, FRAME-1, 1'b1, 1'b0);
    settle(1'b1);
    check_frame("t1", wm, sm, em, N_ROWS, 1'b1, -1, 1'b1);

    // Same frame with valid gaps and clock-enable drops.
    wm = wr_addr_q.size(); sm = start_q.size(); em = err_q.size();
    run_frame(FRAME, FRAME-1, 1'b1, 1'b1);
    settle(1'b1);
    check_frame("t3", wm, sm, em, N_ROWS, 1'b1, -1, 1'b0);

    // Early i_s_last on row 3 word 7.
    wm = wr_addr_q.size(); sm = start_q.size(); em = err_q.size();
    run_frame(3*WPR + 8, 3*WPR + 7, 1'b0, 1'b0);
    settle(1'b0);
    check_frame("t4", wm, sm, em, 3, 1'b0, 3*WPR + 7, 1'b1);

    wm = wr_addr_q.size(); sm = start_q.size(); em = err_q.size();
    run_frame(FRAME, FRAME-1, 1'b0, 1'b0);
    settle(1'b1);
    check_frame("t4_recover", wm, sm, em, N_ROWS, 1'b1, -1, 1'b1);

    // Missing i_s_last on the final word.
    wm = wr_addr_q.size(); sm = start_q.size(); em = err_q.size();
    run_frame(FRAME, -1, 1'b0, 1'b0);
    settle(1'b0);
    check_frame("t5", wm, sm, em, N_ROWS-1, 1'b0, FRAME-1, 1'b1);
    @(negedge i_clk);
    check("t5_ready_again", bus.o_s_ready, 1'b1);
    tick();

    // Async reset while row 5 word 9 is on the bus.
    run_frame(5*WPR + 9, -1, 1'b0, 1'b0);
    check("t6_addr_before_reset", bus.o_addra, 4);
    bus.i_s_data  = {$urandom, $urandom};
    bus.i_s_valid = 1'b1;
    #2;
    i_rst = 1'b1;
    #1;
    check_idle_outputs("t6_async_reset");
    tick();
    tick();
    bus.i_s_valid = 1'b0;
    i_rst = 1'b0;
    wm = wr_addr_q.size(); sm = start_q.size(); em = err_q.size();
    run_frame(FRAME, FRAME-1, 1'b0, 1'b0);
    settle(1'b1);
    check_frame("t6_after_reset", wm, sm, em, N_ROWS, 1'b1, -1, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
